// File: rtl/neuron_stream_loader_if.sv
// neuron_stream_loader_if
// Byte-wide valid/ready command stream feeding neuron_stream_loader.
//   data_in    : command or operand byte (producer -> loader)
//   data_valid : data_in is valid this cycle (producer -> loader)
//   data_ready : loader accepts a byte this cycle (loader -> producer)
// A byte transfers on a rising clock edge where data_valid && data_ready.
interface neuron_stream_loader_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  // Producer side (pins / host)
  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  // Consumer side (the loader)
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/neuron_stream_loader.sv
// neuron_stream_loader
// Byte-serial front end for one LIF neuron. Decodes commands from a byte
// stream, assembles weight/input vectors in a staging register and commits
// them atomically, latches shift/threshold together, and issues enable
// strobes that advance the neuron by one timestep each.
//
// Ports:
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   stream    : neuron_stream_loader_if.slave byte stream (data_in/data_valid/data_ready)
//   weights   : registered SYNAPSES-bit weight vector
//   inputs    : registered SYNAPSES-bit input spike vector
//   shift     : registered 3-bit decay shift
//   threshold : registered THRESHOLD_BITS-bit firing threshold
//   enable    : one-cycle timestep strobe
//   busy      : high whenever the loader is not IDLE
//
// Optional feature: define NEURON_LOADER_AUTO_CLEAR_EN to clear `inputs` on the
// edge that ends the last enable cycle of each STEP (one-shot input spikes).
module neuron_stream_loader #(
  parameter int SYNAPSES       = 32,
  parameter int THRESHOLD_BITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  neuron_stream_loader_if.slave     stream,
  output logic [SYNAPSES-1:0]       weights,
  output logic [SYNAPSES-1:0]       inputs,
  output logic [2:0]                shift,
  output logic [THRESHOLD_BITS-1:0] threshold,
  output logic                      enable,
  output logic                      busy
);

  localparam int BYTES = SYNAPSES / 8;
  // The counter also indexes the two LOAD_CFG bytes, so it is at least 1 bit.
  localparam int CNT_W = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    LOAD_CFG,
    STEP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    byte_cnt;
  logic [SYNAPSES-1:0] staging;
  logic [2:0]          shift_stage;
  logic [5:0]          step_left;
  logic                data_ready_q;
  logic                xfer;
  logic [SYNAPSES-1:0] staged_word;

  assign stream.data_ready = data_ready_q;
  assign xfer              = stream.data_valid && data_ready_q;

  // Staging value with the incoming byte merged into its slot; this is what
  // gets committed on the last byte so the commit lands on the same edge.
  always_comb begin
    staged_word = staging;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_cnt == CNT_W'(k)) begin
        staged_word[8*k +: 8] = stream.data_in;
      end
    end
  end

  // Command decoder / loader FSM. All outputs, including data_ready, are
  // registered so nothing on the byte pins reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      staging      <= '0;
      shift_stage  <= '0;
      step_left    <= '0;
      weights      <= '0;
      inputs       <= '0;
      shift        <= '0;
      threshold    <= '1;
      enable       <= 1'b0;
      busy         <= 1'b0;
      data_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            byte_cnt <= '0;
            staging  <= '0;
            busy     <= 1'b1;
            case (stream.data_in[1:0])
              2'b00:   state <= LOAD_W;
              2'b01:   state <= LOAD_X;
              2'b10:   state <= LOAD_CFG;
              default: begin
                // step_left holds the number of enable cycles remaining
                // after the current one, so count-1 is loaded here.
                state        <= STEP;
                enable       <= 1'b1;
                data_ready_q <= 1'b0;
                step_left    <= stream.data_in[7:2];
              end
            endcase
          end
        end

        LOAD_W, LOAD_X: begin
          if (xfer) begin
            if (byte_cnt == LAST_BYTE) begin
              if (state == LOAD_W) begin
                weights <= staged_word;
              end else begin
                inputs <= staged_word;
              end
              state    <= IDLE;
              busy     <= 1'b0;
              byte_cnt <= '0;
              staging  <= '0;
            end else begin
              staging  <= staged_word;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        LOAD_CFG: begin
          if (xfer) begin
            if (byte_cnt == '0) begin
              shift_stage <= stream.data_in[2:0];
              byte_cnt    <= CNT_W'(1);
            end else begin
              shift     <= shift_stage;
              threshold <= stream.data_in[THRESHOLD_BITS-1:0];
              state     <= IDLE;
              busy      <= 1'b0;
              byte_cnt  <= '0;
            end
          end
        end

        STEP: begin
          if (step_left == '0) begin
            state        <= IDLE;
            enable       <= 1'b0;
            busy         <= 1'b0;
            data_ready_q <= 1'b1;
`ifdef NEURON_LOADER_AUTO_CLEAR_EN
            inputs       <= '0;
`else
            inputs       <= inputs;
`endif
          end else begin
            step_left <= step_left - 6'd1;
          end
        end

        default: begin
          state        <= IDLE;
          enable       <= 1'b0;
          busy         <= 1'b0;
          data_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
